// File: rtl/mem_access_if.sv
// Request/response and memory-side signals of the load/store unit.
// The unit is the slave on the request side and drives the memory port.
interface mem_access_if;
   logic        req;
   logic [31:0] addr;
   logic        wr;
   logic        b_e;
   logic        h_e;
   logic        w_e;
   logic [7:0]  b_in;
   logic [15:0] h_in;
   logic [31:0] w_in;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [29:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // Handshake: req is sampled only while busy=0; the request completes with a
   // single-cycle done pulse (with err=1 when the request was rejected).
   modport slave (
      input  req, addr, wr, b_e, h_e, w_e, b_in, h_in, w_in, mem_rdata,
      output rdata, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output req, addr, wr, b_e, h_e, w_e, b_in, h_in, w_in, mem_rdata,
      input  rdata, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide memory with one-cycle read latency.
// Byte and half stores are performed as a read-modify-write of the containing word.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   mem_access_if.slave bus,
   output logic [2:0]  dbg_state
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      RWAIT = 3'd2,
      WR    = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t      state, state_next;
   logic [31:0] addr_q;
   logic        wr_q;
   logic        is_w_q;
   logic        is_h_q;
   logic [7:0]  b_q;
   logic [15:0] h_q;
   logic [31:0] w_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;

   logic [2:0]  sel_in;
   logic        sel_onehot;
   logic        aligned;
   logic        req_ok;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [31:0] merged;

   assign sel_in     = {bus.w_e, bus.h_e, bus.b_e};
   assign sel_onehot = (sel_in == 3'b001) || (sel_in == 3'b010) || (sel_in == 3'b100);
   assign aligned    = !(bus.h_e && bus.addr[0]) && !(bus.w_e && (bus.addr[1:0] != 2'b00));
   assign req_ok     = sel_onehot && aligned;

   assign byte_sh = {addr_q[1:0], 3'b000};
   assign half_sh = {addr_q[1], 4'b0000};

   // Store word: full replacement, or the captured word with one lane patched.
   always_comb begin
      merged = word_q;
      if (is_w_q) begin
         merged = w_q;
      end else if (is_h_q) begin
         merged = (word_q & ~(32'h0000_FFFF << half_sh)) | ({16'd0, h_q} << half_sh);
      end else begin
         merged = (word_q & ~(32'h0000_00FF << byte_sh)) | ({24'd0, b_q} << byte_sh);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         wr_q   <= 1'b0;
         is_w_q <= 1'b0;
         is_h_q <= 1'b0;
         b_q    <= '0;
         h_q    <= '0;
         w_q    <= '0;
         word_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && bus.req) begin
            addr_q <= bus.addr;
            wr_q   <= bus.wr;
            is_w_q <= bus.w_e;
            is_h_q <= bus.h_e;
            b_q    <= bus.b_in;
            h_q    <= bus.h_in;
            w_q    <= bus.w_in;
         end
         if (state == RWAIT) begin
            word_q <= bus.mem_rdata;
            if (!wr_q) begin
               rdata_q <= bus.mem_rdata >> byte_sh;
            end
         end
      end
   end

   always_comb begin
      state_next    = state;
      bus.busy      = 1'b1;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (bus.req) begin
               if (!req_ok)                  state_next = ERR;
               else if (bus.wr && bus.w_e)   state_next = WR;
               else                          state_next = RD;
            end
         end
         RD: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = addr_q[31:2];
            state_next   = RWAIT;
         end
         RWAIT: begin
            bus.mem_addr = addr_q[31:2];
            state_next   = wr_q ? WR : DONE;
         end
         WR: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = addr_q[31:2];
            bus.mem_wdata = merged;
            state_next    = DONE;
         end
         DONE: begin
            bus.done   = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            bus.done   = 1'b1;
            bus.err    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.rdata = rdata_q;
   assign dbg_state = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized accesses against a
// byte-lane reference model, and hand-written reset / held-request sequences.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   mem_access_if bus();

   mem_access_unit dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Word memory with one-cycle read latency, plus a back-door preload port.
   logic [31:0] mem [0:63];
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [31:0] poke_data;

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_data;
      else if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[5:0]];
   end

   logic [31:0] ref_mem [0:63];
   logic [31:0] exp_rdata;
   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0]  done_m;
      logic [7:0]  err_m;
      logic [7:0]  busy_m;
      logic [7:0]  re_m;
      logic [7:0]  we_m;
      logic [31:0] we_data;
      logic        addr_bad;
      logic        wdata_nz;
   } obs_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  sel;
      logic [7:0]  bd;
      logic [15:0] hd;
      logic [31:0] wd;
      logic [2:0]  exp_done;
      logic        exp_err;
      logic        exp_re;
      logic [2:0]  exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] data);
      @(negedge clk);
      poke_en = 1'b1;
      poke_idx = 6'(idx);
      poke_data = data;
      @(posedge clk);
      #1 poke_en = 1'b0;
      ref_mem[idx] = data;
   endtask

   // Reference: legality is "size one-hot and offset a multiple of size"; stores
   // patch byte lanes of the word; loads return the word shifted by the offset.
   task automatic model(input logic [31:0] a, input logic w, input logic [2:0] sel,
                        input logic [7:0] bd, input logic [15:0] hd, input logic [31:0] wd,
                        output int d, output logic e, output logic re, output int wc,
                        output logic [31:0] wdat);
      int off, idx, size;
      logic [7:0] lanes [4];
      off  = int'(a % 4);
      idx  = int'((a / 4) % 64);
      size = (sel == 3'b001) ? 1 : (sel == 3'b010) ? 2 : (sel == 3'b100) ? 4 : 0;
      d = 0; e = 1'b0; re = 1'b0; wc = 0; wdat = '0;
      if (size == 0 || (off % size) != 0) begin
         d = 1; e = 1'b1;
      end else if (!w) begin
         d = 3; re = 1'b1;
         exp_rdata = ref_mem[idx] >> (8 * off);
      end else if (size == 4) begin
         d = 2; wc = 1; wdat = wd;
         ref_mem[idx] = wd;
      end else begin
         d = 4; re = 1'b1; wc = 3;
         for (int i = 0; i < 4; i++) lanes[i] = ref_mem[idx][8*i +: 8];
         if (size == 1) begin
            lanes[off] = bd;
         end else begin
            lanes[off] = hd[7:0];
            lanes[off+1] = hd[15:8];
         end
         wdat = {lanes[3], lanes[2], lanes[1], lanes[0]};
         ref_mem[idx] = wdat;
      end
   endtask

   // Issue one request, then record six cycles of outputs; inputs are scrambled
   // after the accepting edge and req is held for `hold` cycles.
   task automatic do_access(input logic [31:0] a, input logic w, input logic [2:0] sel,
                            input logic [7:0] bd, input logic [15:0] hd, input logic [31:0] wd,
                            input int hold, output obs_t o);
      o = '0;
      @(negedge clk);
      bus.req = 1'b1;
      bus.addr = a;
      bus.wr = w;
      {bus.w_e, bus.h_e, bus.b_e} = sel;
      bus.b_in = bd;
      bus.h_in = hd;
      bus.w_in = wd;
      @(posedge clk);
      #1;
      if (hold == 0) bus.req = 1'b0;
      bus.addr = $urandom;
      bus.wr = 1'($urandom_range(0, 1));
      bus.b_in = 8'($urandom);
      bus.h_in = 16'($urandom);
      bus.w_in = $urandom;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         o.done_m[k] = bus.done;
         o.err_m[k]  = bus.err;
         o.busy_m[k] = bus.busy;
         o.re_m[k]   = bus.mem_re;
         o.we_m[k]   = bus.mem_we;
         if (bus.mem_we) o.we_data = bus.mem_wdata;
         else if (bus.mem_wdata != 32'd0) o.wdata_nz = 1'b1;
         if ((bus.mem_re || bus.mem_we) && bus.mem_addr != a[31:2]) o.addr_bad = 1'b1;
         if (k >= hold) bus.req = 1'b0;
      end
   endtask

   task automatic check_access(input string name, input obs_t o, input int d, input logic e,
                               input logic re, input int wc, input logic [31:0] wdat);
      logic [7:0] dm;
      dm = 8'd1 << d;
      chk({name, " done"}, 32'(o.done_m), 32'(dm));
      chk({name, " err"}, 32'(o.err_m), e ? 32'(dm) : 32'd0);
      chk({name, " busy"}, 32'(o.busy_m), 32'((8'd1 << (d + 1)) - 8'd2));
      chk({name, " mem_re"}, 32'(o.re_m), re ? 32'h2 : 32'h0);
      chk({name, " mem_we"}, 32'(o.we_m), (wc != 0) ? 32'(8'd1 << wc) : 32'h0);
      if (wc != 0) chk({name, " mem_wdata"}, o.we_data, wdat);
      chk({name, " mem_addr"}, 32'(o.addr_bad), 32'd0);
      chk({name, " wdata_idle"}, 32'(o.wdata_nz), 32'd0);
   endtask

   task automatic run_model(input string name, input logic [31:0] a, input logic w,
                            input logic [2:0] sel, input logic [7:0] bd, input logic [15:0] hd,
                            input logic [31:0] wd, input int hold_extra);
      int d, wc, hold;
      logic e, re;
      logic [31:0] wdat;
      obs_t o;
      model(a, w, sel, bd, hd, wd, d, e, re, wc, wdat);
      hold = (hold_extra != 0) ? d + 1 : 0;
      do_access(a, w, sel, bd, hd, wd, hold, o);
      check_access(name, o, d, e, re, wc, wdat);
      chk({name, " rdata"}, bus.rdata, exp_rdata);
      chk({name, " mem"}, mem[a[7:2]], ref_mem[a[7:2]]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t o;
      int d, wc;
      logic e, re, we_seen;
      logic [31:0] wdat;
      logic [31:0] a;
      logic [2:0] sel;

      rst = 1'b1;
      poke_en = 1'b0; poke_idx = '0; poke_data = '0;
      bus.req = 1'b0; bus.addr = '0; bus.wr = 1'b0;
      bus.b_e = 1'b0; bus.h_e = 1'b0; bus.w_e = 1'b0;
      bus.b_in = '0; bus.h_in = '0; bus.w_in = '0;
      exp_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      chk("reset mem_re", 32'(bus.mem_re), 32'd0);
      chk("reset mem_we", 32'(bus.mem_we), 32'd0);
      chk("reset mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("reset mem_wdata", bus.mem_wdata, 32'd0);
      chk("reset rdata", bus.rdata, 32'd0);

      // rst and req on the same edge: reset wins
      bus.req = 1'b1; bus.addr = 32'h10; bus.w_e = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_prio busy", 32'(bus.busy), 32'd0);
      chk("rst_prio mem_re", 32'(bus.mem_re), 32'd0);
      bus.req = 1'b0; bus.w_e = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 64; i++) poke(i, $urandom);
      poke(4, 32'hDEAD_BEEF);
      poke(8, 32'h1122_3344);

      vecs[0]  = '{32'h10, 1'b0, 3'b100, 8'h00, 16'h0000, 32'h0, 3'd3, 1'b0, 1'b1, 3'd0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[1]  = '{32'h13, 1'b0, 3'b001, 8'h00, 16'h0000, 32'h0, 3'd3, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_00DE, 32'hDEAD_BEEF};
      vecs[2]  = '{32'h12, 1'b0, 3'b010, 8'h00, 16'h0000, 32'h0, 3'd3, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_DEAD, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h21, 1'b1, 3'b001, 8'hAA, 16'h0000, 32'h0, 3'd4, 1'b0, 1'b1, 3'd3, 32'h1122_AA44, 32'h0000_DEAD, 32'h1122_AA44};
      vecs[4]  = '{32'h22, 1'b0, 3'b100, 8'h00, 16'h0000, 32'h0, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0000_DEAD, 32'h1122_AA44};
      vecs[5]  = '{32'h23, 1'b0, 3'b010, 8'h00, 16'h0000, 32'h0, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0000_DEAD, 32'h1122_AA44};
      vecs[6]  = '{32'h20, 1'b1, 3'b000, 8'h55, 16'h0000, 32'h0, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0000_DEAD, 32'h1122_AA44};
      vecs[7]  = '{32'h20, 1'b0, 3'b011, 8'h00, 16'h0000, 32'h0, 3'd1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0000_DEAD, 32'h1122_AA44};
      vecs[8]  = '{32'h20, 1'b1, 3'b100, 8'h00, 16'h0000, 32'hCAFE_F00D, 3'd2, 1'b0, 1'b0, 3'd1, 32'hCAFE_F00D, 32'h0000_DEAD, 32'hCAFE_F00D};
      vecs[9]  = '{32'h22, 1'b1, 3'b010, 8'h00, 16'hBEEF, 32'h0, 3'd4, 1'b0, 1'b1, 3'd3, 32'hBEEF_F00D, 32'h0000_DEAD, 32'hBEEF_F00D};
      vecs[10] = '{32'h21, 1'b0, 3'b001, 8'h00, 16'h0000, 32'h0, 3'd3, 1'b0, 1'b1, 3'd0, 32'h0, 32'h00BE_EFF0, 32'hBEEF_F00D};
      vecs[11] = '{32'h20, 1'b0, 3'b100, 8'h00, 16'h0000, 32'h0, 3'd3, 1'b0, 1'b1, 3'd0, 32'h0, 32'hBEEF_F00D, 32'hBEEF_F00D};

      for (int i = 0; i < 12; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         model(vecs[i].addr, vecs[i].wr, vecs[i].sel, vecs[i].bd, vecs[i].hd, vecs[i].wd,
               d, e, re, wc, wdat);
         do_access(vecs[i].addr, vecs[i].wr, vecs[i].sel, vecs[i].bd, vecs[i].hd, vecs[i].wd, 0, o);
         check_access(nm, o, int'(vecs[i].exp_done), vecs[i].exp_err, vecs[i].exp_re,
                      int'(vecs[i].exp_we), vecs[i].exp_wdata);
         chk({nm, " rdata"}, bus.rdata, vecs[i].exp_rdata);
         chk({nm, " mem"}, mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
      end

      // req held high through busy and the DONE cycle: exactly one access
      run_model("held_req", 32'h10, 1'b0, 3'b100, 8'h0, 16'h0, 32'h0, 1);

      // reset while a half-store RMW sits in RWAIT
      @(negedge clk);
      bus.req = 1'b1; bus.addr = 32'h32; bus.wr = 1'b1;
      {bus.w_e, bus.h_e, bus.b_e} = 3'b010; bus.h_in = 16'h5555;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      chk("rmw_rst rd mem_re", 32'(bus.mem_re), 32'd1);
      @(negedge clk);
      chk("rmw_rst rwait busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      we_seen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_rdata = '0;
      chk("rmw_rst busy", 32'(bus.busy), 32'd0);
      chk("rmw_rst done", 32'(bus.done), 32'd0);
      chk("rmw_rst err", 32'(bus.err), 32'd0);
      chk("rmw_rst mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rmw_rst mem_wdata", bus.mem_wdata, 32'd0);
      chk("rmw_rst rdata", bus.rdata, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (bus.mem_we) we_seen = 1'b1;
         @(negedge clk);
      end
      chk("rmw_rst no write", 32'(we_seen), 32'd0);
      chk("rmw_rst mem", mem[12], ref_mem[12]);

      for (int i = 0; i < 40; i++) begin
         int r;
         a = 32'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         sel = (r < 9) ? 3'(1 << (r % 3)) : 3'($urandom_range(0, 7));
         run_model($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), sel,
                   8'($urandom), 16'($urandom), $urandom, $urandom_range(0, 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: req  in  1  access request, sampled only in IDLE.
REQ-004 SHALL have: addr  in  32  byte address (from load/store address adder).
REQ-005 SHALL have: wr  in  1  1 = store, 0 = load.
REQ-006 SHALL have: b_e / h_e / w_e  in  1 each  byte / half / word size select.
REQ-007 SHALL have: b_in  in  8; h_in  in  16; w_in  in  32  store data per size.
REQ-008 SHALL have: rdata  out  32  load word, right-justified: addressed byte/half in bits [7:0]/[15:0].
REQ-009 SHALL have: busy  out  1; done  out  1; err  out  1.
REQ-010 SHALL have: mem_addr  out  30  word address; mem_re  out  1; mem_we  out  1; mem_wdata  out  32; mem_rdata  in  32 (memory returns data one cycle after mem_re).

Function
REQ-011 SHALL implement states IDLE, RD, RWAIT, WR, DONE, ERR.
REQ-012 In IDLE with req=1, SHALL latch addr, wr, size selects and store data at that edge; inputs SHALL NOT be sampled again until the next IDLE.
REQ-013 Accept SHALL go to ERR if size selects are not one-hot, or half with addr[0]=1, or word with addr[1:0]!=0; no memory strobe SHALL assert for that request.
REQ-014 Valid load SHALL go IDLE->RD->RWAIT->DONE->IDLE; done high in the 3rd cycle after the accepting edge.
REQ-015 Valid word store SHALL go IDLE->WR->DONE->IDLE; done high in the 2nd cycle after accept.
REQ-016 Valid byte/half store SHALL read-modify-write: IDLE->RD->RWAIT->WR->DONE->IDLE; done in 4th cycle after accept.
REQ-017 mem_re SHALL be 1 only in RD; mem_we SHALL be 1 only in WR; mem_addr SHALL equal latched addr[31:2] in RD, RWAIT, WR.
REQ-018 In RWAIT, mem_rdata SHALL be captured into an internal word register at the end of that cycle.
REQ-019 In WR, mem_wdata SHALL be: word -> w_in; half -> captured word with bits [16*addr[1]+15 : 16*addr[1]] replaced by h_in; byte -> captured word with bits [8*addr[1:0]+7 : 8*addr[1:0]] replaced by b_in; other bytes unchanged.
REQ-020 For loads, rdata SHALL be captured word logically shifted right by 8*addr[1:0], zero-filled; updated on leaving RWAIT and held until the next load's RWAIT.
REQ-021 done SHALL be 1 for exactly one cycle in DONE and ERR; err SHALL be 1 only in ERR.
REQ-022 busy SHALL be 1 in every state except IDLE; req while busy SHALL be ignored, not queued.
REQ-023 DONE and ERR SHALL return to IDLE unconditionally; a req present in that cycle SHALL be ignored, accepted only if still high in IDLE.
REQ-024 Outside WR, mem_wdata SHALL be 0.

Reset
REQ-025 With rst=1 at a rising edge, state SHALL become IDLE and rdata, captured word and latched request SHALL become 0, regardless of state (including mid-RMW).
REQ-026 During and after reset until next accept: busy=0, done=0, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-027 rst SHALL take priority over req on the same edge; a write aborted before WR SHALL leave memory unmodified.

Verification
REQ-028 Word load: mem[0x10>>2]=0xDEADBEEF, req addr=0x10 w_e=1 wr=0 -> mem_re at cycle 1, done cycle 3, rdata=0xDEADBEEF.
REQ-029 Byte load offset: same word, addr=0x13 b_e=1 -> rdata=0x000000DE; addr=0x12 h_e=1 -> rdata=0x0000DEAD.
REQ-030 Byte store RMW: word=0x11223344, addr=0x21 b_e=1 wr=1 b_in=0xAA -> mem_re cycle 1, mem_we cycle 3 with mem_wdata=0x1122AA44, done cycle 4.
REQ-031 Misaligned: addr=0x22 w_e=1 -> cycle 1 err=1 done=1, mem_re=mem_we=0 throughout; addr=0x23 h_e=1 -> same.
REQ-032 Reset mid-operation: half store accepted, rst=1 in RWAIT -> next cycle IDLE, mem_we never asserts, memory word unchanged; req held high during busy -> exactly one access.
